// File: rtl/phy_traffic_checker.sv
// phy_traffic_checker: ramp traffic generator and loopback checker for the PHY.
// Define PHY_TRAFFIC_ERR_INJECT_EN to add the inject port (single-bit error).
module phy_traffic_checker #(
    parameter int         LANES     = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hBC,
    parameter int         NUM_WORDS = 64,
    parameter int         MAX_LAT   = 16,
    parameter int         ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
`ifdef PHY_TRAFFIC_ERR_INJECT_EN
    input  logic                 inject,
`endif
    output logic [8*LANES-1:0]   tx_data,
    output logic                 tx_valid,
    input  logic [8*LANES-1:0]   rx_data,
    input  logic                 rx_valid,
    output logic [31:0]          tx_count,
    output logic [31:0]          rx_count,
    output logic [ERR_W-1:0]     err_count,
    output logic                 locked,
    output logic                 done,
    output logic                 fail
);

    localparam int W  = 8 * LANES;
    localparam int LW = $clog2(MAX_LAT + 1);
    localparam logic [W-1:0] IDLE_W = {LANES{IDLE_BYTE}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic {C_HUNT, C_LOCK} chk_t;

    state_t state, state_nx;
    chk_t   chk, chk_nx;

    logic [LW-1:0] drain_cnt;
    logic [LW-1:0] hunt_cnt;
    logic          hunt_act;
    logic          hunt_to;
    logic          cmp_err;
    logic [W-1:0]  inj_mask;

    logic clear;
    logic last_word;
    logic rx_match;
    logic drain_ok;
    logic drain_exp;
    logic to_done;
    logic hunt_run;
    logic hunt_hit;

    // Ramp byte n*LANES+k per lane, with the comma byte replaced.
    function automatic logic [W-1:0] pay_word(input logic [31:0] n);
        logic [7:0] b;
        pay_word = '0;
        for (int k = 0; k < LANES; k++) begin
            b = n[7:0] * 8'(LANES) + 8'(k);
            if (b == IDLE_BYTE) b = IDLE_BYTE ^ 8'h01;
            pay_word[8*k +: 8] = b;
        end
    endfunction

`ifdef PHY_TRAFFIC_ERR_INJECT_EN
    assign inj_mask = W'(inject);
`else
    assign inj_mask = '0;
`endif

    assign clear     = start && (state == S_IDLE || state == S_DONE);
    assign last_word = (NUM_WORDS != 0) && (tx_count == 32'(NUM_WORDS - 1));
    assign rx_match  = (rx_data == pay_word(rx_count));
    assign drain_ok  = (rx_count == tx_count);
    assign drain_exp = !rx_valid && (drain_cnt == LW'(MAX_LAT - 1));
    assign to_done   = (state == S_DRAIN) && (state_nx == S_DONE);
    assign hunt_run  = (chk == C_HUNT) && (tx_valid || hunt_act) && !hunt_to;
    assign hunt_hit  = hunt_run && (hunt_cnt == LW'(MAX_LAT - 1));
    assign locked    = (chk == C_LOCK);

    // Run FSM next state.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_RUN;
            S_RUN:          if (stop || last_word) state_nx = S_DRAIN;
            S_DRAIN:        if (drain_ok || drain_exp) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Checker FSM next state: lock on the first matching word 0.
    always_comb begin
        chk_nx = chk;
        if (clear) begin
            chk_nx = C_HUNT;
        end else if (chk == C_HUNT && rx_valid && rx_match) begin
            chk_nx = C_LOCK;
        end
    end

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            chk   <= C_HUNT;
        end else begin
            state <= state_nx;
            chk   <= chk_nx;
        end
    end

    // Transmit side: registered payload or idle words plus word count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= IDLE_W;
            tx_valid <= 1'b0;
            tx_count <= '0;
        end else if (clear) begin
            tx_data  <= IDLE_W;
            tx_valid <= 1'b0;
            tx_count <= '0;
        end else if (state == S_RUN) begin
            tx_data  <= pay_word(tx_count) ^ inj_mask;
            tx_valid <= 1'b1;
            tx_count <= tx_count + 32'd1;
        end else begin
            tx_data  <= IDLE_W;
            tx_valid <= 1'b0;
        end
    end

    // Receive side: word count, registered compare, hunt timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count  <= '0;
            err_count <= '0;
            cmp_err   <= 1'b0;
            hunt_act  <= 1'b0;
            hunt_cnt  <= '0;
            hunt_to   <= 1'b0;
        end else if (clear) begin
            rx_count  <= '0;
            err_count <= '0;
            cmp_err   <= 1'b0;
            hunt_act  <= 1'b0;
            hunt_cnt  <= '0;
            hunt_to   <= 1'b0;
        end else begin
            cmp_err <= 1'b0;
            if (rx_valid && (chk == C_LOCK || rx_match)) begin
                rx_count <= rx_count + 32'd1;
            end
            if (rx_valid && chk == C_LOCK && !rx_match) begin
                cmp_err <= 1'b1;
            end
            if (cmp_err && !(&err_count)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (tx_valid) begin
                hunt_act <= 1'b1;
            end
            if (hunt_hit) begin
                hunt_to <= 1'b1;
            end else if (hunt_run) begin
                hunt_cnt <= hunt_cnt + LW'(1);
            end
        end
    end

    // Run status: drain idle timer, done flag and sticky fail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else if (clear) begin
            drain_cnt <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            if (state == S_DRAIN && !rx_valid) begin
                drain_cnt <= drain_cnt + LW'(1);
            end else begin
                drain_cnt <= '0;
            end
            if (to_done) begin
                done <= 1'b1;
            end
            if (hunt_hit || cmp_err || (to_done && !drain_ok)) begin
                fail <= 1'b1;
            end
        end
    end

endmodule
